double_precision_fpu: RTL and testbench
=======================================

Name: double_precision_fpu

Overview:
- Registered IEEE-754 binary64 arithmetic unit for the custom RV32 FP extension; executes FADD.D, FSUB.D, FMUL.D and FDIV.D selected by funct3.
- Sits beside the integer ALU in execute; operands come from the 64-bit FP register pair, and the result returns to writeback.
- Fully pipelined: one operation is accepted every cycle, with a fixed 1-cycle latency.

Parameters:
- None. Width is fixed at 64-bit binary64: 1 sign bit, 11 exponent bits with bias 1023, 52 fraction bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1  input  64  operand A, binary64.
- rs2  input  64  operand B, binary64.
- funct3  input  3  operation: 000 FADD, 001 FSUB (rs1-rs2), 010 FMUL, 011 FDIV (rs1/rs2), 1xx reserved.
- result  output  64  registered binary64 result.
- valid  output  1  registered; 1 when result holds a supported-op result.

Behaviour:
- Reset: on a rising clk edge with rst=1, result=64'h0 and valid=0. rst overrides any operation in flight, which is discarded.
- Latency: inputs are sampled every rising edge with rst=0; result and valid for those inputs appear after that edge (1 cycle). There is no enable or stall; each new cycle overwrites the previous output.
- Supported funct3 (000–011) sets valid=1. Reserved funct3 (1xx) sets valid=0 and result=0.
- Operand classes:
  - exp=0 is zero. Subnormals are flushed to zero with their sign kept.
  - exp=7FF with frac=0 is ±inf.
  - exp=7FF with frac≠0 is NaN.
- Canonical NaN is 64'h7FF8000000000000, the only NaN ever output.
- ADD/SUB: FSUB is FADD with rs2's sign inverted.
  - Align to the larger exponent with a 3-bit guard/round/sticky extension.
  - Add or subtract the 53-bit significands (hidden 1), then normalise with a leading-zero shift.
  - Exact cancellation gives +0. (-0)+(-0) gives -0.
- MUL: sign is XOR of the operand signs; exponent is e1+e2-1023; the 53x53 significand product is normalised by at most 1 bit.
- DIV: sign is XOR of the operand signs; exponent is e1-e2+1023; the quotient is a combinational 56-bit restoring long division of the significands, normalised by at most 1 bit.
- Rounding: round-toward-zero (truncate) for all ops; guard/round/sticky bits are discarded.
- Overflow (biased exponent ≥ 7FF after normalisation) gives ±inf.
- Underflow (biased exponent ≤ 0) gives signed zero.
- Special cases, checked in this order:
  - Any NaN operand gives canonical NaN.
  - FDIV with rs2 = ±0 (any rs1) gives canonical NaN; this is the team's decided divide-by-zero result.
  - inf-inf (effective subtraction) gives NaN.
  - inf×0 gives NaN.
  - inf/inf gives NaN.
  - Otherwise an inf operand gives signed inf (finite/inf = signed 0).
  - 0×finite gives signed 0.
  - 0/finite gives signed 0.
  - x±0 returns x exactly.
- All arithmetic is combinational between the input and output registers.

Optional Feature:
- Macro: DP_FPU_FLAGS_EN.
- When defined, add an output port fflags [4:0] = {NV, DZ, OF, UF, NX}, registered with result and cleared on reset and on reserved funct3.
  - NV: invalid (NaN produced).
  - DZ: FDIV by zero.
  - OF: overflow.
  - UF: underflow or flush to zero.
  - NX: any discarded nonzero guard/round/sticky bits, or OF/UF.
- When undefined, the port and its logic are absent; result and valid behaviour are unchanged.

Test Plan:
- Reset: hold rst=1 with funct3=000 and valid operands → after each edge, result=0 and valid=0. Deassert rst → the next edge gives a correct result with valid=1.
- FADD: 3FF0000000000000 + 4000000000000000 → 4008000000000000, valid=1. BFF0000000000000 + 3FF0000000000000 → 0000000000000000.
- FSUB: 4000000000000000 - 3FF0000000000000 → 3FF0000000000000. 3FF0000000000000 - BFF0000000000000 → 4000000000000000.
- FMUL: 3FF0000000000000 × 4000000000000000 → 4000000000000000. BFF0000000000000 × 4000000000000000 → C000000000000000. 7FF0000000000000 × 0 → 7FF8000000000000.
- FDIV: 4000000000000000 / 3FF0000000000000 → 4000000000000000. 4000000000000000 / 0 → 7FF8000000000000. 3FF0000000000000 / 4008000000000000 → 3FD5555555555555 (truncated).
- Back-to-back and reserved ops: change the op every cycle → each result follows its inputs by exactly one edge. funct3=100 → valid=0, result=0. A 32-bit zero-extended random operand (subnormal) is treated as zero: ADD returns the other operand, MUL returns ±0.

Source files
------------

// File: rtl/double_precision_fpu.sv
// double_precision_fpu: binary64 FADD/FSUB/FMUL/FDIV with truncation and a single register stage.
// Optional build macro DP_FPU_FLAGS_EN adds the registered fflags {NV,DZ,OF,UF,NX} output.
module double_precision_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic [2:0]  funct3,
  output logic [63:0] result,
  output logic        valid
`ifdef DP_FPU_FLAGS_EN
  ,
  output logic [4:0]  fflags
`endif
);
  // valid is a pure qualifier with no ready: it is 1 in the cycle after a supported
  // op was sampled and 0 after reset or a reserved funct3; every edge overwrites it.
  localparam logic [63:0] CANON_NAN = 64'h7FF8000000000000;
  localparam logic [62:0] INF_MAG   = 63'h7FF0000000000000;

  logic        s1, s2, s2e, sx;
  logic [10:0] e1, e2;
  logic [51:0] f1, f2;
  logic [52:0] m1, m2;
  logic        zero1, zero2, inf1, inf2, nan1, nan2;
  logic        supported, op_add, op_mul, op_div;

  assign {s1, e1, f1} = rs1;
  assign {s2, e2, f2} = rs2;
  assign s2e   = s2 ^ (funct3 == 3'b001);
  assign sx    = s1 ^ s2;
  assign m1    = {1'b1, f1};
  assign m2    = {1'b1, f2};
  assign zero1 = (e1 == 11'd0);
  assign zero2 = (e2 == 11'd0);
  assign inf1  = (e1 == 11'h7FF) && (f1 == 52'd0);
  assign inf2  = (e2 == 11'h7FF) && (f2 == 52'd0);
  assign nan1  = (e1 == 11'h7FF) && (f1 != 52'd0);
  assign nan2  = (e2 == 11'h7FF) && (f2 != 52'd0);

  assign supported = ~funct3[2];
  assign op_add    = (funct3[2:1] == 2'b00);
  assign op_mul    = (funct3 == 3'b010);
  assign op_div    = (funct3 == 3'b011);

  // Add/sub: larger magnitude goes to the "a" side so the subtraction never goes negative.
  logic               swap, sa, sb;
  logic [10:0]        ea, eb, ed;
  logic [52:0]        ma, mb;
  logic [55:0]        mb_ext, mb_al;
  logic [56:0]        sum;
  logic [5:0]         lz;
  logic [54:0]        norm;
  logic signed [12:0] add_exp;
  logic [51:0]        add_mant;
  logic               add_cancel, add_nx;

  always_comb begin
    swap   = {e2, f2} > {e1, f1};
    sa     = swap ? s2e : s1;
    sb     = swap ? s1 : s2e;
    ea     = swap ? e2 : e1;
    eb     = swap ? e1 : e2;
    ma     = swap ? m2 : m1;
    mb     = swap ? m1 : m2;
    ed     = ea - eb;
    mb_ext = {mb, 3'b000};
    if (ed >= 11'd56) begin
      mb_al = 56'd1;
    end else begin
      mb_al    = mb_ext >> ed;
      mb_al[0] = mb_al[0] | (|(mb_ext & ~({56{1'b1}} << ed)));
    end
    if (sa == sb) sum = {1'b0, ma, 3'b000} + {1'b0, mb_al};
    else          sum = {1'b0, ma, 3'b000} - {1'b0, mb_al};
    lz = 6'd0;
    for (int i = 0; i < 56; i++) begin
      if (sum[i]) lz = 6'(55 - i);
    end
    norm       = sum[54:0] << lz;
    add_cancel = (sum == 57'd0);
    if (sum[56]) begin
      add_mant = sum[55:4];
      add_exp  = $signed({2'b00, ea}) + 13'sd1;
      add_nx   = |sum[3:0];
    end else begin
      add_mant = norm[54:3];
      add_exp  = $signed({2'b00, ea}) - $signed({7'b0, lz});
      add_nx   = |norm[2:0];
    end
  end

  // Multiply: the product of two [1,2) significands lies in [1,4).
  logic [105:0]       prod;
  logic signed [12:0] mul_exp;
  logic [51:0]        mul_mant;
  logic               mul_nx;

  assign prod     = {53'd0, m1} * {53'd0, m2};
  assign mul_exp  = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 13'sd1023
                    + $signed({12'd0, prod[105]});
  assign mul_mant = prod[105] ? prod[104:53] : prod[103:52];
  assign mul_nx   = prod[105] ? |prod[52:0] : |prod[51:0];

  // Divide: 56 quotient bits, the first of which has weight 1 (quotient in (0.5,2)).
  logic [54:0]        rem;
  logic [55:0]        quo;
  logic signed [12:0] div_exp;
  logic [51:0]        div_mant;
  logic               div_nx;

  always_comb begin
    rem = {2'b00, m1};
    quo = '0;
    for (int i = 55; i >= 0; i--) begin
      if (rem >= {2'b00, m2}) begin
        quo[i] = 1'b1;
        rem    = rem - {2'b00, m2};
      end
      rem = rem << 1;
    end
  end

  assign div_exp  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + 13'sd1023
                    - $signed({12'd0, ~quo[55]});
  assign div_mant = quo[55] ? quo[54:3] : quo[53:2];
  assign div_nx   = (|rem) | (quo[55] ? |quo[2:0] : |quo[1:0]);

  logic               sel_sign, sel_nx, arith_of, arith_uf;
  logic signed [12:0] sel_exp;
  logic [51:0]        sel_mant;
  logic [63:0]        arith_res;

  assign sel_sign  = op_add ? sa : sx;
  assign sel_exp   = op_add ? add_exp  : (op_mul ? mul_exp  : div_exp);
  assign sel_mant  = op_add ? add_mant : (op_mul ? mul_mant : div_mant);
  assign sel_nx    = op_add ? add_nx   : (op_mul ? mul_nx   : div_nx);
  assign arith_of  = (sel_exp >= 13'sd2047);
  assign arith_uf  = (sel_exp <= 13'sd0);
  assign arith_res = arith_of ? {sel_sign, INF_MAG} :
                     arith_uf ? {sel_sign, 63'd0}   : {sel_sign, sel_exp[10:0], sel_mant};

  // Priority order of the special cases matters: NaN inputs win over divide-by-zero, etc.
  logic        special;
  logic [63:0] special_res, res_n;

  always_comb begin
    special     = 1'b1;
    special_res = 64'd0;
    if (nan1 || nan2)                                          special_res = CANON_NAN;
    else if (op_div && zero2)                                  special_res = CANON_NAN;
    else if (op_add && inf1 && inf2 && (s1 != s2e))            special_res = CANON_NAN;
    else if (op_mul && ((inf1 && zero2) || (zero1 && inf2)))   special_res = CANON_NAN;
    else if (op_div && inf1 && inf2)                           special_res = CANON_NAN;
    else if (inf1 || inf2) begin
      if (op_add)      special_res = {inf1 ? s1 : s2e, INF_MAG};
      else if (inf1)   special_res = {sx, INF_MAG};
      else if (op_mul) special_res = {sx, INF_MAG};
      else             special_res = {sx, 63'd0};
    end
    else if (!op_add && (zero1 || zero2))                      special_res = {sx, 63'd0};
    else if (zero1 && zero2)                                   special_res = {s1 & s2e, 63'd0};
    else if (zero2)                                            special_res = rs1;
    else if (zero1)                                            special_res = {s2e, rs2[62:0]};
    else if (add_cancel)                                       special_res = 64'd0;
    else                                                       special     = 1'b0;
  end

  assign res_n = !supported ? 64'd0 : (special ? special_res : arith_res);

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 64'd0;
      valid  <= 1'b0;
    end else begin
      result <= res_n;
      valid  <= supported;
    end
  end

`ifdef DP_FPU_FLAGS_EN
  logic sub_flush, nv, dz, of, uf, nx;

  assign sub_flush = (zero1 && (f1 != 52'd0)) || (zero2 && (f2 != 52'd0));
  assign nv = supported && (res_n == CANON_NAN);
  assign dz = supported && op_div && zero2 && !nan1 && !nan2;
  assign of = supported && !special && arith_of;
  assign uf = supported && ((!special && arith_uf) || sub_flush);
  assign nx = of || uf || (supported && !special && sel_nx);

  always_ff @(posedge clk) begin
    if (rst) fflags <= 5'd0;
    else     fflags <= {nv, dz, of, uf, nx};
  end
`else
  logic unused_sticky;
  assign unused_sticky = sel_nx;
`endif
endmodule

// File: tb/tb_double_precision_fpu.sv
// Scoreboard bench for double_precision_fpu: driver pushes expected {valid,result}, monitor pops.
module tb_double_precision_fpu;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] rs1, rs2;
  logic [2:0]  funct3;
  logic [63:0] result;
  logic        valid;
`ifdef DP_FPU_FLAGS_EN
  logic [4:0]  fflags;
`endif

  localparam logic [63:0] NAN = 64'h7FF8000000000000;

  always #5 clk = ~clk;

  double_precision_fpu dut (
    .clk    (clk),
    .rst    (rst),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .result (result),
`ifdef DP_FPU_FLAGS_EN
    .fflags (fflags),
`endif
    .valid  (valid)
  );

  logic [64:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference: exact integer arithmetic on significands, then truncate to 53 bits.
  function automatic logic [64:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] f);
    logic        sa, sb, sx, rs;
    int          ea, eb, sc, msb, e, hi, lo, base;
    logic [51:0] fa, fb;
    logic [52:0] ma, mb;
    bit          za, zb, ia, ib, na, nb;
    logic [255:0] x, y, s;
    if (f[2]) return 65'd0;
    sa = a[63];
    sb = b[63] ^ (f == 3'd1);
    sx = a[63] ^ b[63];
    ea = int'(a[62:52]);
    eb = int'(b[62:52]);
    fa = a[51:0];
    fb = b[51:0];
    ma = {1'b1, fa};
    mb = {1'b1, fb};
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 2047) && (fa == 0);
    ib = (eb == 2047) && (fb == 0);
    na = (ea == 2047) && (fa != 0);
    nb = (eb == 2047) && (fb != 0);
    if (na || nb)                               return {1'b1, NAN};
    if (f == 3'd3 && zb)                        return {1'b1, NAN};
    if (f < 3'd2 && ia && ib && sa != sb)       return {1'b1, NAN};
    if (f == 3'd2 && ((ia && zb) || (za && ib))) return {1'b1, NAN};
    if (f == 3'd3 && ia && ib)                  return {1'b1, NAN};
    if (ia || ib) begin
      if (f < 3'd2) return {1'b1, ia ? sa : sb, 11'h7FF, 52'd0};
      if (f == 3'd2 || ia) return {1'b1, sx, 11'h7FF, 52'd0};
      return {1'b1, sx, 63'd0};
    end
    if (f >= 3'd2 && (za || zb)) return {1'b1, sx, 63'd0};
    if (za && zb) return {1'b1, sa & sb, 63'd0};
    if (zb)       return {1'b1, a};
    if (za)       return {1'b1, sb, b[62:0]};
    if (f < 3'd2) begin
      hi   = (ea > eb) ? ea : eb;
      lo   = (ea > eb) ? eb : ea;
      base = (hi - lo > 120) ? hi - 120 : lo;
      x    = 256'(ma) << (((ea > base) ? ea : base) - base);
      y    = 256'(mb) << (((eb > base) ? eb : base) - base);
      sc   = base - 1075;
      if (sa == sb)   begin s = x + y; rs = sa; end
      else if (x == y) return {1'b1, 64'd0};
      else if (x > y) begin s = x - y; rs = sa; end
      else            begin s = y - x; rs = sb; end
    end else if (f == 3'd2) begin
      s  = 256'(ma) * 256'(mb);
      sc = ea + eb - 2150;
      rs = sx;
    end else begin
      s  = (256'(ma) << 110) / 256'(mb);
      sc = ea - eb - 110;
      rs = sx;
    end
    msb = 0;
    for (int i = 0; i < 256; i++) if (s[i]) msb = i;
    e = msb + sc + 1023;
    if (e >= 2047) return {1'b1, rs, 11'h7FF, 52'd0};
    if (e <= 0)    return {1'b1, rs, 63'd0};
    if (msb >= 52) s = s >> (msb - 52);
    else           s = s << (52 - msb);
    return {1'b1, rs, 11'(e), s[51:0]};
  endfunction

  function automatic logic [63:0] rand_op();
    logic [31:0] r1, r2;
    logic [10:0] e;
    r1 = $urandom;
    r2 = $urandom;
    e  = 11'd0;
    case ($urandom_range(0, 15))
      0:       return {r1[31], 63'd0};
      1:       return {32'd0, r2};
      2:       return {r1[31], 11'h7FF, 52'd0};
      3:       return {r1[31], 11'h7FF, r1[19:0], r2 | 32'd1};
      4:       e = 11'($urandom_range(1990, 2046));
      5:       e = 11'($urandom_range(1, 50));
      6:       e = 11'($urandom_range(1, 2046));
      default: e = 11'($urandom_range(1013, 1033));
    endcase
    return {r1[31], e, r1[19:0], r2};
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                       input logic r, input logic [64:0] e, input string n);
    @(negedge clk);
    rst    = r;
    rs1    = a;
    rs2    = b;
    funct3 = f;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic dvec(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                      input logic [64:0] e, input string n);
    drive(a, b, f, 1'b0, e, n);
  endtask

  always @(posedge clk) begin : monitor
    logic [64:0] e;
    string       n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if ({valid, result} !== e) begin
        errors++;
        $display("FAIL %s: got valid=%0b result=%h, expected valid=%0b result=%h",
                 n, valid, result, e[64], e[63:0]);
      end
    end
  end

  initial begin : stimulus
    logic [63:0] a, b;
    logic [2:0]  f;
    logic        r;
    rst    = 1'b1;
    rs1    = 64'd0;
    rs2    = 64'd0;
    funct3 = 3'd0;
    repeat (2) @(negedge clk);
    repeat (3) drive(64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 1'b1, 65'd0, "reset");

    dvec(64'h3FF0000000000000, 64'h4000000000000000, 3'd0, {1'b1, 64'h4008000000000000}, "fadd_1p2");
    dvec(64'hBFF0000000000000, 64'h3FF0000000000000, 3'd0, {1'b1, 64'h0000000000000000}, "fadd_cancel");
    dvec(64'h4000000000000000, 64'h3FF0000000000000, 3'd1, {1'b1, 64'h3FF0000000000000}, "fsub_2m1");
    dvec(64'h3FF0000000000000, 64'hBFF0000000000000, 3'd1, {1'b1, 64'h4000000000000000}, "fsub_1mn1");
    dvec(64'h3FF0000000000000, 64'h4000000000000000, 3'd2, {1'b1, 64'h4000000000000000}, "fmul_1x2");
    dvec(64'hBFF0000000000000, 64'h4000000000000000, 3'd2, {1'b1, 64'hC000000000000000}, "fmul_neg");
    dvec(64'h7FF0000000000000, 64'h0000000000000000, 3'd2, {1'b1, NAN},                  "fmul_infx0");
    dvec(64'h4000000000000000, 64'h3FF0000000000000, 3'd3, {1'b1, 64'h4000000000000000}, "fdiv_2d1");
    dvec(64'h4000000000000000, 64'h0000000000000000, 3'd3, {1'b1, NAN},                  "fdiv_by0");
    dvec(64'h3FF0000000000000, 64'h4008000000000000, 3'd3, {1'b1, 64'h3FD5555555555555}, "fdiv_third");
    dvec(64'h3FF0000000000000, 64'h4000000000000000, 3'd4, 65'd0,                        "reserved_100");
    dvec(64'h3FF0000000000000, 64'h4000000000000000, 3'd7, 65'd0,                        "reserved_111");
    dvec(64'h8000000000000000, 64'h8000000000000000, 3'd0, {1'b1, 64'h8000000000000000}, "fadd_negzero");
    dvec(64'h3FF0000000000000, 64'h3AF0000000000000, 3'd1, {1'b1, 64'h3FEFFFFFFFFFFFFF}, "fsub_trunc");
    dvec(64'h7FE0000000000000, 64'h4000000000000000, 3'd2, {1'b1, 64'h7FF0000000000000}, "fmul_ovf");
    dvec(64'h0010000000000000, 64'h0010000000000000, 3'd2, {1'b1, 64'h0000000000000000}, "fmul_unf");
    dvec(64'h7FF0000000000000, 64'h7FF0000000000000, 3'd1, {1'b1, NAN},                  "fsub_infinf");
    dvec(64'h7FF0000000000000, 64'h7FF0000000000000, 3'd0, {1'b1, 64'h7FF0000000000000}, "fadd_infinf");
    dvec(64'h3FF0000000000000, 64'hFFF0000000000000, 3'd3, {1'b1, 64'h8000000000000000}, "fdiv_fin_inf");
    dvec(64'h7FF4000000000000, 64'h3FF0000000000000, 3'd0, {1'b1, NAN},                  "nan_in");
    dvec(64'h4000000000000000, 64'h0000000012345678, 3'd0, {1'b1, 64'h4000000000000000}, "fadd_subn");
    dvec(64'hC000000000000000, 64'h0000000012345678, 3'd2, {1'b1, 64'h8000000000000000}, "fmul_subn");
    dvec(64'h0000000012345678, 64'h4000000000000000, 3'd1, {1'b1, 64'hC000000000000000}, "fsub_subn");

    for (int i = 0; i < 800; i++) begin
      a = rand_op();
      b = ($urandom_range(0, 7) == 0) ? (a ^ 64'($urandom_range(0, 3))) : rand_op();
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r = ($urandom_range(0, 49) == 0);
      drive(a, b, f, r, r ? 65'd0 : ref_model(a, b, f), r ? "rand_reset" : "rand_op");
    end

    @(negedge clk);
    rst    = 1'b0;
    funct3 = 3'd4;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
